// File: rtl/exe_muldiv_unit_if.sv
// HI/LO multiply/divide unit bus: EXE-stage request side and result/stall side.
interface exe_muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             EXE_Flush;
   logic             EXE_Wr;
   logic             EXE_MulDivReq;
   logic [1:0]       EXE_MulDivOp;
   logic [WIDTH-1:0] EXE_BusA;
   logic [WIDTH-1:0] EXE_BusB;
   logic             MD_Stall;
   logic             MD_Done;
   logic [WIDTH-1:0] MD_Hi;
   logic [WIDTH-1:0] MD_Lo;

   // Pipeline / hazard side drives requests and observes results.
   modport master (
      output EXE_Flush, EXE_Wr, EXE_MulDivReq, EXE_MulDivOp, EXE_BusA, EXE_BusB,
      input  MD_Stall, MD_Done, MD_Hi, MD_Lo
   );

   // The arithmetic unit itself.
   modport slave (
      input  EXE_Flush, EXE_Wr, EXE_MulDivReq, EXE_MulDivOp, EXE_BusA, EXE_BusB,
      output MD_Stall, MD_Done, MD_Hi, MD_Lo
   );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle HI/LO unit for the EXE stage: pipelined multiply, radix-2 restoring divide.
// Signed operations run on magnitudes; result signs are applied at the end.
module exe_muldiv_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_STAGES = 1
) (
   input logic              clk,
   input logic              rst,
   exe_muldiv_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH-1:0]   opa_q;     // multiplicand magnitude, or dividend/quotient shift reg
   logic [WIDTH-1:0]   opb_q;     // multiplier / divisor magnitude
   logic [WIDTH-1:0]   rem_q;
   logic               res_neg_q; // negate product or quotient
   logic               rem_neg_q; // negate remainder
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               op_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_raw, prod, mul_res;
   logic [WIDTH:0]     part;
   logic               fits;
   logic [WIDTH-1:0]   rem_nxt, quo_nxt, lo_fix, hi_fix;

   // Operand magnitudes, product, one restoring-divide step and final sign fix-up.
   always_comb begin
      op_signed = ~bus.EXE_MulDivOp[0];
      a_neg     = op_signed & bus.EXE_BusA[WIDTH-1];
      b_neg     = op_signed & bus.EXE_BusB[WIDTH-1];
      a_mag     = a_neg ? -bus.EXE_BusA : bus.EXE_BusA;
      b_mag     = b_neg ? -bus.EXE_BusB : bus.EXE_BusB;
      prod_raw  = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
      prod      = res_neg_q ? -prod_raw : prod_raw;
      part      = {rem_q, opa_q[WIDTH-1]};
      fits      = part >= {1'b0, opb_q};
      rem_nxt   = fits ? (part[WIDTH-1:0] - opb_q) : part[WIDTH-1:0];
      quo_nxt   = {opa_q[WIDTH-2:0], fits};
      lo_fix    = res_neg_q ? -opa_q : opa_q;
      hi_fix    = rem_neg_q ? -rem_q : rem_q;
   end

   if (MUL_STAGES == 1) begin : g_mul_direct
      // Single stage: the result register on entry to DONE is the only product stage.
      always_comb mul_res = prod;
   end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];

      // Free-running product pipeline; operands stay stable for the whole MUL phase.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= prod;
            for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      always_comb mul_res = pipe_q[MUL_STAGES-2];
   end

   // Stall covers the request cycle in IDLE and all busy states, never while in reset.
   always_comb begin
      bus.MD_Stall = rst & ((state_q == StIdle & bus.EXE_MulDivReq) |
                            state_q == StMul | state_q == StDiv | state_q == StFix);
      bus.MD_Done  = done_q;
      bus.MD_Hi    = hi_q;
      bus.MD_Lo    = lo_q;
   end

   // Control FSM with registered results; flush wins over everything else.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rem_q     <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (bus.EXE_Flush) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.EXE_MulDivReq) begin
                  opa_q     <= a_mag;
                  opb_q     <= b_mag;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  rem_neg_q <= a_neg;
                  if (bus.EXE_MulDivOp[1]) begin
                     // Divide by zero keeps the all-ones quotient unsigned-looking.
                     res_neg_q <= (a_neg ^ b_neg) & (bus.EXE_BusB != '0);
                     state_q   <= StDiv;
                  end else begin
                     res_neg_q <= a_neg ^ b_neg;
                     state_q   <= StMul;
                  end
               end
            end
            StMul: begin
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(MUL_STAGES - 1)) begin
                  {hi_q, lo_q} <= mul_res;
                  done_q       <= 1'b1;
                  state_q      <= StDone;
               end
            end
            StDiv: begin
               rem_q <= rem_nxt;
               opa_q <= quo_nxt;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
            end
            StFix: begin
               hi_q    <= hi_fix;
               lo_q    <= lo_fix;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               if (bus.EXE_Wr) begin
                  done_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule
